// File: rtl/jimmy_result_collector.sv
// rtl/jimmy_result_collector.sv - collects done results from jimmy cores into a drained record FIFO
//
// Purpose: watches each core's out_strobe done bit, captures out_port_2 on the
// strobe's falling edge, arbitrates pending captures round-robin into a FIFO of
// {core_id, result} records, and tracks per-core completion.
// Optional feature macro: JIMMY_COLLECTOR_WATCHDOG_EN (cycle watchdog driving timeout).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   strobe_bus      core i out_strobe at [4i+3:4i]
//   result_bus      core i out_port_2 at [8i+7:8i]
//   clear_done      pulse clearing done_mask/all_done
//   out_valid/out_ready/out_core_id/out_result  head-of-FIFO record port
//   done_mask, all_done  sticky per-core finished flags and their registered AND
//   drop_count      saturating count of results lost to a still-pending capture
//   fifo_count      FIFO occupancy
//   timeout         watchdog flag (0 when the watchdog is compiled out)
module jimmy_result_collector #(
  parameter int NUM_CORES      = 4,
  parameter int STROBE_BIT     = 2,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4*NUM_CORES-1:0]     strobe_bus,
  input  logic [8*NUM_CORES-1:0]     result_bus,
  input  logic                       clear_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_core_id,
  output logic [7:0]                 out_result,
  output logic [NUM_CORES-1:0]       done_mask,
  output logic                       all_done,
  output logic [7:0]                 drop_count,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_CORES-1:0] cur, prev, fall, pending, clr, drop_vec;
  logic [7:0]           cap_data [NUM_CORES];
  logic [2:0]           rr_ptr, grant;
  logic                 any_pending, push, pop;
  logic [7:0]           push_data;
  logic [3:0]           n_drops;
  logic [8:0]           drop_sum;
  logic [10:0]          mem [DEPTH];
  logic [10:0]          head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 unused_strobe;

  assign unused_strobe = ^strobe_bus;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) cur[i] = strobe_bus[4*i+STROBE_BIT];
  end
  assign fall = prev & ~cur;

  // Round-robin: rr_ptr holds the first core to consider (one past the last grant).
  always_comb begin
    any_pending = 1'b0;
    grant       = 3'd0;
    for (int k = 0; k < NUM_CORES; k++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!any_pending && pending[i] && (i == ((int'(rr_ptr) + k) % NUM_CORES))) begin
          any_pending = 1'b1;
          grant       = 3'(i);
        end
      end
    end
  end

  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = any_pending & ((fifo_count != CW'(DEPTH)) | pop);

  always_comb begin
    clr       = '0;
    push_data = 8'd0;
    drop_vec  = '0;
    n_drops   = 4'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push && (int'(grant) == i)) begin
        clr[i]    = 1'b1;
        push_data = cap_data[i];
      end
      // A pending slot being pushed this cycle is free to take the new capture.
      drop_vec[i] = fall[i] & pending[i] & ~clr[i];
      n_drops     = n_drops + {3'd0, drop_vec[i]};
    end
  end

  assign drop_sum = {1'b0, drop_count} + {5'd0, n_drops};

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      pending    <= '0;
      rr_ptr     <= 3'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done_mask  <= '0;
      all_done   <= 1'b0;
      drop_count <= 8'd0;
      for (int i = 0; i < NUM_CORES; i++) cap_data[i] <= 8'd0;
    end else begin
      prev <= cur;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (fall[i] && !drop_vec[i]) begin
          pending[i]  <= 1'b1;
          cap_data[i] <= result_bus[8*i +: 8];
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
        end
      end

      if (push) begin
        mem[wr_ptr] <= {grant, push_data};
        wr_ptr      <= wr_ptr + AW'(1);
        rr_ptr      <= (int'(grant) == NUM_CORES - 1) ? 3'd0 : grant + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      // A fall coinciding with clear_done keeps that core's bit set.
      done_mask <= (clear_done ? '0 : done_mask) | fall;
      all_done  <= clear_done ? 1'b0 : &done_mask;
    end
  end

  assign out_valid   = (fifo_count != '0);
  assign head        = mem[rd_ptr];
  // Gate the unreset storage so an empty FIFO presents zeros.
  assign out_core_id = out_valid ? head[10:8] : 3'd0;
  assign out_result  = out_valid ? head[7:0]  : 8'd0;

`ifdef JIMMY_COLLECTOR_WATCHDOG_EN
  logic [15:0] wd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      if (clear_done) begin
        wd_count <= 16'd0;
      end else if (!all_done && wd_count != 16'hFFFF) begin
        wd_count <= wd_count + 16'd1;
      end
      if (!all_done && wd_count == 16'(TIMEOUT_CYCLES)) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jimmy_result_collector.sv
// tb/tb_jimmy_result_collector.sv - scoreboard bench for jimmy_result_collector
module tb_jimmy_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] strobe_bus;
  logic [31:0] result_bus;
  logic        clear_done;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_core_id;
  logic [7:0]  out_result;
  logic [3:0]  done_mask;
  logic        all_done;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_count;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q [$];

  jimmy_result_collector #(
    .NUM_CORES(4), .STROBE_BIT(2), .DEPTH(4), .TIMEOUT_CYCLES(100)
  ) u_dut (
    .clk(clk), .reset(reset), .strobe_bus(strobe_bus), .result_bus(result_bus),
    .clear_done(clear_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_core_id(out_core_id), .out_result(out_result), .done_mask(done_mask),
    .all_done(all_done), .drop_count(drop_count), .fifo_count(fifo_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobe(input int core, input logic val);
    strobe_bus[4*core+2] = val;
  endtask

  task automatic set_result(input int core, input logic [7:0] val);
    result_bus[8*core +: 8] = val;
  endtask

  // Monitor: every accepted head record must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got core %0d result %0d expected none", out_core_id, out_result);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("record", {21'd0, out_core_id, out_result}, {21'd0, e});
      end
    end
  end

  initial begin
    reset      = 1'b1;
    strobe_bus = 16'h4444;
    result_bus = 32'd0;
    clear_done = 1'b0;
    out_ready  = 1'b0;

    // Reset held 3 cycles with strobes high
    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_core_id", {29'd0, out_core_id}, 0);
    check("rst_result", {24'd0, out_result}, 0);
    check("rst_done_mask", {28'd0, done_mask}, 0);
    check("rst_all_done", {31'd0, all_done}, 0);
    check("rst_drop", {24'd0, drop_count}, 0);
    check("rst_fifo_count", {29'd0, fifo_count}, 0);
    check("rst_timeout", {31'd0, timeout}, 0);

    // Single capture latency on core 3
    reset = 1'b0;
    tick();
    set_strobe(3, 1'b0);
    set_result(3, 8'd55);
    exp_q.push_back({3'd3, 8'd55});
    tick();
    check("lat_valid_e0", {31'd0, out_valid}, 0);
    tick();
    check("lat_valid_e1", {31'd0, out_valid}, 1);
    check("lat_core_id", {29'd0, out_core_id}, 3);
    check("lat_result", {24'd0, out_result}, 55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_valid", {31'd0, out_valid}, 0);
    check("pop_fifo_count", {29'd0, fifo_count}, 0);

    // Simultaneous finish of all cores
    strobe_bus = 16'h4444;
    tick();
    result_bus = {8'd40, 8'd30, 8'd20, 8'd10};
    strobe_bus = 16'h0000;
    for (int c = 0; c < 4; c++) exp_q.push_back({3'(c), 8'(10 * (c + 1))});
    tick();
    check("sim_done_mask", {28'd0, done_mask}, 4'hF);
    check("sim_all_done_e0", {31'd0, all_done}, 0);
    check("sim_fifo_e0", {29'd0, fifo_count}, 0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("sim_fifo_count", {29'd0, fifo_count}, 32'(n));
      if (n == 1) check("sim_all_done_e1", {31'd0, all_done}, 1);
    end
    check("sim_drop", {24'd0, drop_count}, 0);

    // Backpressure and drop on core 0 while FIFO is full
    set_strobe(0, 1'b1);
    set_result(0, 8'd1);
    tick();
    set_strobe(0, 1'b0);
    tick();
    tick();
    set_strobe(0, 1'b1);
    set_result(0, 8'd2);
    tick();
    tick();
    set_strobe(0, 1'b0);
    tick();
    tick();
    check("bp_fifo_full", {29'd0, fifo_count}, 4);
    check("drop_count", {24'd0, drop_count}, 1);
    exp_q.push_back({3'd0, 8'd1});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_fifo_after_pulse", {29'd0, fifo_count}, 4);
    check("bp_drop_after_pulse", {24'd0, drop_count}, 1);

    // clear_done with core 3 falling in the same cycle
    check("pre_clear_all_done", {31'd0, all_done}, 1);
    set_strobe(3, 1'b1);
    set_result(3, 8'd99);
    tick();
    set_strobe(3, 1'b0);
    clear_done = 1'b1;
    exp_q.push_back({3'd3, 8'd99});
    tick();
    clear_done = 1'b0;
    check("clr_done_mask", {28'd0, done_mask}, 4'h8);
    check("clr_all_done", {31'd0, all_done}, 0);
    check("clr_fifo_count", {29'd0, fifo_count}, 4);
    tick();
    check("clr_all_done_next", {31'd0, all_done}, 0);
    check("clr_timeout", {31'd0, timeout}, 0);

    // Drain everything, bounded
    out_ready = 1'b1;
    for (int n = 0; n < 20 && (exp_q.size() != 0 || fifo_count != 0); n++) tick();
    out_ready = 1'b0;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_fifo_count", {29'd0, fifo_count}, 0);
    check("drain_valid", {31'd0, out_valid}, 0);
    check("drain_drop", {24'd0, drop_count}, 1);

    // Reset mid-operation discards a queued record
    set_strobe(1, 1'b1);
    tick();
    set_strobe(1, 1'b0);
    repeat (3) tick();
    check("pre_reset_fifo", {29'd0, fifo_count}, 1);
    reset = 1'b1;
    tick();
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_fifo", {29'd0, fifo_count}, 0);
    check("mid_rst_done_mask", {28'd0, done_mask}, 0);
    check("mid_rst_drop", {24'd0, drop_count}, 0);

    // Watchdog: only core 0 finishes after reset
    strobe_bus = 16'h0004;
    result_bus = 32'd0;
    reset      = 1'b0;
    out_ready  = 1'b1;
    tick();
    set_strobe(0, 1'b0);
    set_result(0, 8'd5);
    exp_q.push_back({3'd0, 8'd5});
    for (int n = 2; n <= 140; n++) begin
      tick();
      if (n == 10) begin
        check("wd_done_mask", {28'd0, done_mask}, 4'h1);
        check("wd_all_done", {31'd0, all_done}, 0);
        check("wd_record_drained", exp_q.size(), 0);
      end
      if (n == 90) check("wd_timeout_early", {31'd0, timeout}, 0);
`ifdef JIMMY_COLLECTOR_WATCHDOG_EN
      if (n == 115) check("wd_timeout_set", {31'd0, timeout}, 1);
      if (n == 140) check("wd_timeout_sticky", {31'd0, timeout}, 1);
`else
      if (n == 115) check("wd_timeout_off", {31'd0, timeout}, 0);
      if (n == 140) check("wd_timeout_off_late", {31'd0, timeout}, 0);
`endif
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jimmy_result_collector.md
Name: jimmy_result_collector

Overview:
- Downstream consumer of one or more jimmy cores; sits beside program_memory/data_memory in the multicore top.
- Watches each core's out_strobe "done" bit and out_port_2 result, and captures the result on the strobe's falling edge.
- Queues {core_id, result} records in a FIFO drained through a valid/ready port.
- Tracks which cores have finished and raises all_done, replacing ad-hoc bench monitoring.

Parameters:
- NUM_CORES, 4, number of cores monitored (1..8).
- STROBE_BIT, 2, index of the done bit within each core's 4-bit out_strobe.
- DEPTH, 8, FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 20000, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- strobe_bus  in  4*NUM_CORES  core i out_strobe at bits [4i+3:4i].
- result_bus  in  8*NUM_CORES  core i out_port_2 at bits [8i+7:8i].
- clear_done  in  1  synchronous pulse; clears done_mask and all_done only.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head record when out_valid is high.
- out_core_id  out  3  core index of the head record.
- out_result  out  8  result of the head record.
- done_mask  out  NUM_CORES  sticky per-core finished flags.
- all_done  out  1  registered AND of done_mask.
- drop_count  out  8  saturating count of lost results.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- timeout  out  1  watchdog flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset (reset=1 at a rising edge) clears:
  - all outputs: out_valid=0, out_core_id=0, out_result=0, done_mask=0, all_done=0, drop_count=0, fifo_count=0, timeout=0;
  - internal state: prev_strobe, pending flags, captured data, FIFO pointers and the round-robin pointer.
  - Reset mid-operation discards all queued and pending records.
- Edge detect, per core i:
  - prev[i] <= strobe_bus[4i+STROBE_BIT] every cycle.
  - fall[i] = prev[i] & ~current bit.
  - prev resets to 0, so a strobe already low at reset release gives no edge.
- Capture:
  - At the rising edge where fall[i]=1: if pending[i]=0, set pending[i]=1 and latch result_bus slice i, sampled in the same cycle as fall[i].
  - If pending[i]=1, the new result is dropped and drop_count increments, saturating at 255.
  - done_mask[i] <= 1 on any fall[i]. This includes a dropped capture.
- Arbiter:
  - At most one pending record is pushed per cycle, chosen round-robin starting after the last granted core.
  - The granted pending[i] clears on push.
  - Push is allowed when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs in the same cycle.
  - When the FIFO is full, pending records wait; this waiting is not a drop.
  - A core whose pending bit is cleared this cycle may capture again in the same cycle: new data wins and pending stays 1.
- Latency:
  - Falling edge sampled at edge E → pending at E.
  - Pushed at E+1 if no contention.
  - out_valid high during the cycle after E+1 when the FIFO was empty. Minimum 2 cycles.
- FIFO:
  - out_valid = (fifo_count!=0).
  - out_core_id/out_result show the head entry combinationally from storage.
  - Pop happens when out_valid & out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - out_ready while empty has no effect.
- all_done <= &done_mask (one cycle after the final done bit sets).
- clear_done:
  - Zeroes done_mask and all_done on that edge.
  - A fall in the same cycle wins for that core (bit set).
  - FIFO, pending state and drop_count are unaffected.

Optional Feature:
- Macro: JIMMY_COLLECTOR_WATCHDOG_EN.
- Defined:
  - A 16-bit cycle counter starts at 0 after reset and increments each cycle while all_done=0.
  - timeout is set (sticky) when the counter reaches TIMEOUT_CYCLES with all_done=0.
  - timeout is cleared only by reset.
  - The counter freezes once all_done=1 and restarts from 0 on clear_done.
- Undefined: no counter logic exists and timeout is constant 0.

Test Plan:
- Reset behaviour: NUM_CORES=1; hold reset 3 cycles while strobe is high → all outputs 0. Release, drop strobe bit 2 with result 8'd55 → out_valid rises exactly 2 cycles after the edge with out_core_id=0, out_result=55. Assert out_ready for 1 cycle → out_valid=0, fifo_count=0.
- Simultaneous finish: NUM_CORES=4 with out_ready=0; all cores fall in the same cycle with results 10, 20, 30, 40 → pushes happen on 4 consecutive cycles in order 0,1,2,3 → fifo_count=4, done_mask=4'b1111, all_done=1 one cycle after the last done bit, drop_count=0.
- Backpressure: DEPTH=2, out_ready=0; cores 0, 1, 2 fall → fifo_count=2 and pending[2] held. Pulse out_ready one cycle → core 2 record (core 2, its value) enters the FIFO in that same cycle, fifo_count stays 2, drop_count=0.
- Drop path: core 0 falls twice, 4 cycles apart, with result 1 then 2, while the FIFO is full and out_ready=0 → drop_count=1. Drain → the FIFO yields result 1 for core 0, never 2.
- clear_done: after all_done=1, pulse clear_done → done_mask=0 and all_done=0 next cycle, queued records unchanged. Core 3 falls in the same cycle as clear_done → done_mask=4'b1000.
- With JIMMY_COLLECTOR_WATCHDOG_EN and TIMEOUT_CYCLES=100: only core 0 finishes → timeout=1 at cycle 100 after reset and stays 1. Without the macro → timeout=0 throughout.
